// File: rtl/red_pitaya_gpio_pkg.sv
// red_pitaya_gpio_pkg: register map and version constants for the GPIO block
package red_pitaya_gpio_pkg;
    localparam logic [19:0] A_CFG = 20'h00;
    localparam logic [19:0] A_DIR = 20'h04;
    localparam logic [19:0] A_OUT = 20'h08;
    localparam logic [19:0] A_SET = 20'h0C;
    localparam logic [19:0] A_CLR = 20'h10;
    localparam logic [19:0] A_TGL = 20'h14;
    localparam logic [19:0] A_IN  = 20'h18;
    localparam logic [19:0] A_IRE = 20'h1C;
    localparam logic [19:0] A_IFE = 20'h20;
    localparam logic [19:0] A_STS = 20'h24;
    localparam logic [19:0] A_DEB = 20'h28;
    localparam logic [7:0]  CFG_VER = 8'h02;
endpackage

// File: rtl/red_pitaya_gpio_deb.sv
// red_pitaya_gpio_deb: 2-flop synchronizer plus counting debouncer for one pin
module red_pitaya_gpio_deb
    import red_pitaya_gpio_pkg::*;
#(
    parameter int CW = 16
) (
    input  logic          i_clk,
    input  logic          i_rstn,
    input  logic          i_pin,
    input  logic [CW-1:0] i_len,
    input  logic          i_clr,
    output logic          o_deb
);
    logic [1:0]    r_sync;
    logic [CW-1:0] r_cnt;
    logic          r_deb;
    // synchronize the pin, then accept a new level once it has disagreed for i_len+1 cycles
    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            r_sync <= '0;
            r_cnt  <= '0;
            r_deb  <= 1'b0;
        end else begin
            r_sync <= {r_sync[0], i_pin};
            if (i_clr || r_sync[1] == r_deb) r_cnt <= '0;
            else if (r_cnt == i_len) begin
                r_deb <= r_sync[1];
                r_cnt <= '0;
            end else r_cnt <= r_cnt + 1'b1;
        end
    end
    assign o_deb = r_deb;
endmodule

// File: rtl/red_pitaya_gpio.sv
// red_pitaya_gpio: bus-mapped GPIO with debounced inputs and edge interrupts
module red_pitaya_gpio
    import red_pitaya_gpio_pkg::*;
#(
    parameter int NGPIO   = 16,
    parameter int CW      = 16,
    parameter int DEB_RST = 0
) (
    input  logic             clk_i,
    input  logic             rstn_i,
    input  logic [NGPIO-1:0] gpio_dat_i,
    output logic [NGPIO-1:0] gpio_dat_o,
    output logic [NGPIO-1:0] gpio_dir_o,
    output logic             irq_o,
    input  logic [31:0]      sys_addr,
    input  logic [31:0]      sys_wdata,
    input  logic             sys_wen,
    input  logic             sys_ren,
    output logic [31:0]      sys_rdata,
    output logic             sys_err,
    output logic             sys_ack
);
    logic [NGPIO-1:0] r_dir, r_out, r_ire, r_ife, r_sts, r_in_q;
    logic [CW-1:0]    r_deb_len;
    logic             r_irq, r_ack;
    logic [31:0]      r_rdata, w_rdata;
    logic [NGPIO-1:0] w_in, w_wd, w_evt;
    logic [19:0]      w_addr;
    logic             w_wr_dir, w_wr_out, w_wr_set, w_wr_clr, w_wr_tgl;
    logic             w_wr_ire, w_wr_ife, w_wr_sts, w_wr_deb;
    logic             w_unused;

    assign w_addr   = sys_addr[19:0];
    assign w_wd     = sys_wdata[NGPIO-1:0];
    assign w_unused = ^{sys_addr, sys_wdata};
    assign w_wr_dir = sys_wen && w_addr == A_DIR;
    assign w_wr_out = sys_wen && w_addr == A_OUT;
    assign w_wr_set = sys_wen && w_addr == A_SET;
    assign w_wr_clr = sys_wen && w_addr == A_CLR;
    assign w_wr_tgl = sys_wen && w_addr == A_TGL;
    assign w_wr_ire = sys_wen && w_addr == A_IRE;
    assign w_wr_ife = sys_wen && w_addr == A_IFE;
    assign w_wr_sts = sys_wen && w_addr == A_STS;
    assign w_wr_deb = sys_wen && w_addr == A_DEB;
    assign w_evt    = (w_in & ~r_in_q & r_ire) | (~w_in & r_in_q & r_ife);

    genvar g;
    for (g = 0; g < NGPIO; g++) begin : g_pin
        red_pitaya_gpio_deb #(.CW(CW)) u_deb (
            .i_clk  (clk_i),
            .i_rstn (rstn_i),
            .i_pin  (gpio_dat_i[g]),
            .i_len  (r_deb_len),
            .i_clr  (w_wr_deb),
            .o_deb  (w_in[g])
        );
    end

    // read data mux; unmapped and write-only addresses read as zero
    always_comb begin
        w_rdata = '0;
        case (w_addr)
            A_CFG:   w_rdata = {8'h0, 8'(CW), 8'(NGPIO), CFG_VER};
            A_DIR:   w_rdata = 32'(r_dir);
            A_OUT:   w_rdata = 32'(r_out);
            A_IN:    w_rdata = 32'(w_in);
            A_IRE:   w_rdata = 32'(r_ire);
            A_IFE:   w_rdata = 32'(r_ife);
            A_STS:   w_rdata = 32'(r_sts);
            A_DEB:   w_rdata = 32'(r_deb_len);
            default: w_rdata = '0;
        endcase
    end

    // register writes, edge-event capture (set beats W1C) and bus handshake
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            r_dir     <= '0;
            r_out     <= '0;
            r_ire     <= '0;
            r_ife     <= '0;
            r_sts     <= '0;
            r_in_q    <= '0;
            r_deb_len <= CW'(DEB_RST);
            r_irq     <= 1'b0;
            r_ack     <= 1'b0;
            r_rdata   <= '0;
        end else begin
            if (w_wr_dir) r_dir <= w_wd;
            r_out <= w_wr_out ? w_wd :
                     w_wr_set ? r_out | w_wd :
                     w_wr_clr ? r_out & ~w_wd :
                     w_wr_tgl ? r_out ^ w_wd : r_out;
            if (w_wr_ire) r_ire <= w_wd;
            if (w_wr_ife) r_ife <= w_wd;
            if (w_wr_deb) r_deb_len <= sys_wdata[CW-1:0];
            r_in_q  <= w_in;
            r_sts   <= (r_sts & ~(w_wr_sts ? w_wd : '0)) | w_evt;
            r_irq   <= |r_sts;
            r_ack   <= sys_wen | sys_ren;
            r_rdata <= sys_ren ? w_rdata : '0;
        end
    end

    assign gpio_dat_o = r_out;
    assign gpio_dir_o = r_dir;
    assign irq_o      = r_irq;
    assign sys_rdata  = r_rdata;
    assign sys_ack    = r_ack;
    assign sys_err    = 1'b0;
endmodule

// File: tb/tb_red_pitaya_gpio.sv
// tb_red_pitaya_gpio: randomized self-checking bench against a register/pulse-rule model
module tb_red_pitaya_gpio;
    logic        clk = 1'b0;
    logic        rstn;
    logic [15:0] gpio_dat_i, gpio_dat_o, gpio_dir_o;
    logic        irq_o, sys_wen, sys_ren, sys_err, sys_ack;
    logic [31:0] sys_addr, sys_wdata, sys_rdata;
    int          n_cmp = 0;
    int          n_err = 0;
    logic [15:0] m_dir, m_out, m_ire, m_ife;
    logic [31:0] v, d;
    int          op;

    always #5 clk = ~clk;

    red_pitaya_gpio dut (
        .clk_i      (clk),
        .rstn_i     (rstn),
        .gpio_dat_i (gpio_dat_i),
        .gpio_dat_o (gpio_dat_o),
        .gpio_dir_o (gpio_dir_o),
        .irq_o      (irq_o),
        .sys_addr   (sys_addr),
        .sys_wdata  (sys_wdata),
        .sys_wen    (sys_wen),
        .sys_ren    (sys_ren),
        .sys_rdata  (sys_rdata),
        .sys_err    (sys_err),
        .sys_ack    (sys_ack)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    task automatic bus_wr(input logic [31:0] a, input logic [31:0] dat);
        @(posedge clk); #1;
        sys_addr = a; sys_wdata = dat; sys_wen = 1'b1;
        @(posedge clk); #1;
        sys_wen = 1'b0;
        chk("wr_ack", 32'(sys_ack), 32'd1);
    endtask

    task automatic bus_rd(input logic [31:0] a, output logic [31:0] dat);
        @(posedge clk); #1;
        sys_addr = a; sys_ren = 1'b1;
        @(posedge clk); #1;
        sys_ren = 1'b0;
        chk("rd_ack", 32'(sys_ack), 32'd1);
        dat = sys_rdata;
    endtask

    // pin k held high for len cycles with DEB_LEN=dl; IN is polled every cycle
    task automatic pulse(input int k, input int dl, input int len, input logic [15:0] er, input logic [15:0] ef);
        int rise = -1;
        int fall = -1;
        logic [31:0] rv;
        logic [15:0] exp_sts;
        bus_wr(32'h28, 32'(dl));
        bus_wr(32'h1C, 32'(er));
        bus_wr(32'h20, 32'(ef));
        bus_wr(32'h24, 32'hFFFF);
        @(posedge clk); #1;
        gpio_dat_i[k] = 1'b1; sys_addr = 32'h18; sys_ren = 1'b1;
        for (int i = 1; i <= len + dl + 12; i++) begin
            @(posedge clk); #1;
            if (i == len) gpio_dat_i[k] = 1'b0;
            if (sys_rdata[k] && rise < 0) rise = i;
            if (!sys_rdata[k] && rise >= 0 && fall < 0) fall = i;
        end
        sys_ren = 1'b0;
        if (len >= dl + 1) begin
            chk("rise_lat", 32'(rise), 32'(dl + 4));
            chk("fall_lat", 32'(fall), 32'(len + dl + 4));
        end else chk("glitch_rise", 32'(rise), 32'hFFFF_FFFF);
        exp_sts = (len >= dl + 1) ? ((er | ef) & (16'd1 << k)) : 16'd0;
        bus_rd(32'h24, rv);
        chk("sts", rv, 32'(exp_sts));
        chk("irq", 32'(irq_o), 32'(exp_sts != 0));
        bus_wr(32'h24, 32'(exp_sts));
        bus_rd(32'h24, rv);
        chk("sts_clr", rv, 32'd0);
        chk("irq_clr", 32'(irq_o), 32'd0);
    endtask

    initial begin
        rstn = 1'b0; gpio_dat_i = '0; sys_wen = 1'b0; sys_ren = 1'b0;
        sys_addr = '0; sys_wdata = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out", 32'(gpio_dat_o), 32'd0);
        chk("rst_dir", 32'(gpio_dir_o), 32'd0);
        chk("rst_irq", 32'(irq_o), 32'd0);
        chk("rst_ack", 32'(sys_ack), 32'd0);
        chk("rst_err", 32'(sys_err), 32'd0);
        chk("rst_rdata", sys_rdata, 32'd0);
        rstn = 1'b1;

        bus_rd(32'h00, v);  chk("cfg", v, 32'h0010_1002);
        bus_rd(32'h28, v);  chk("deb_rst", v, 32'd0);
        bus_rd(32'h2C, v);  chk("unmapped", v, 32'd0);

        bus_wr(32'h04, 32'h00FF);
        bus_wr(32'h08, 32'h0F0F);
        chk("dir_port", 32'(gpio_dir_o), 32'h00FF);
        chk("out_port", 32'(gpio_dat_o), 32'h0F0F);
        bus_rd(32'h04, v);  chk("dir_rd", v, 32'h00FF);
        bus_rd(32'h08, v);  chk("out_rd", v, 32'h0F0F);

        bus_wr(32'h08, 32'h00F0);
        bus_wr(32'h0C, 32'h0003);
        bus_wr(32'h10, 32'h0010);
        bus_wr(32'h14, 32'h8001);
        bus_rd(32'h08, v);  chk("set_clr_tgl", v, 32'h80E2);
        bus_rd(32'h0C, v);  chk("wo_set_rd", v, 32'd0);

        m_dir = 16'h00FF; m_out = 16'h80E2; m_ire = '0; m_ife = '0;
        for (int i = 0; i < 40; i++) begin
            op = int'($urandom_range(0, 6));
            d  = $urandom;
            case (op)
                0: begin bus_wr(32'h04, d); m_dir = d[15:0]; end
                1: begin bus_wr(32'h08, d); m_out = d[15:0]; end
                2: begin bus_wr(32'h0C, d); m_out = m_out | d[15:0]; end
                3: begin bus_wr(32'h10, d); m_out = m_out & ~d[15:0]; end
                4: begin bus_wr(32'h14, d); m_out = m_out ^ d[15:0]; end
                5: begin bus_wr(32'h1C, d); m_ire = d[15:0]; end
                default: begin bus_wr(32'h20, d); m_ife = d[15:0]; end
            endcase
            chk("rnd_dir_port", 32'(gpio_dir_o), 32'(m_dir));
            chk("rnd_out_port", 32'(gpio_dat_o), 32'(m_out));
            op = int'($urandom_range(0, 3));
            case (op)
                0: begin bus_rd(32'h04, v); chk("rnd_dir", v, 32'(m_dir)); end
                1: begin bus_rd(32'h08, v); chk("rnd_out", v, 32'(m_out)); end
                2: begin bus_rd(32'h1C, v); chk("rnd_ire", v, 32'(m_ire)); end
                default: begin bus_rd(32'h20, v); chk("rnd_ife", v, 32'(m_ife)); end
            endcase
        end

        pulse(0, 4, 4, 16'h0001, 16'h0000);
        pulse(0, 4, 10, 16'h0001, 16'h0000);
        pulse(3, 0, 1, 16'h0000, 16'h0008);
        for (int i = 0; i < 10; i++)
            pulse(int'($urandom_range(0, 15)), int'($urandom_range(0, 6)), int'($urandom_range(1, 12)),
                  16'($urandom), 16'($urandom));

        bus_wr(32'h28, 32'd0);
        bus_wr(32'h1C, 32'h1);
        bus_wr(32'h20, 32'h0);
        bus_wr(32'h24, 32'hFFFF);
        @(posedge clk); #1;
        gpio_dat_i[0] = 1'b1;
        repeat (8) @(posedge clk);
        bus_rd(32'h24, v);  chk("irq_sts_set", v, 32'h1);
        chk("irq_o_set", 32'(irq_o), 32'd1);
        bus_wr(32'h24, 32'h1);
        chk("irq_o_hold", 32'(irq_o), 32'd1);
        @(posedge clk); #1;
        chk("irq_o_drop", 32'(irq_o), 32'd0);
        bus_rd(32'h24, v);  chk("irq_sts_clr", v, 32'd0);

        bus_wr(32'h20, 32'h1);
        @(posedge clk); #1;
        gpio_dat_i[0] = 1'b0;
        repeat (8) @(posedge clk);
        bus_rd(32'h24, v);  chk("fall_sts", v, 32'h1);
        @(posedge clk); #1;
        gpio_dat_i[0] = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        sys_addr = 32'h24; sys_wdata = 32'h1; sys_wen = 1'b1;
        @(posedge clk); #1;
        sys_wen = 1'b0;
        bus_rd(32'h24, v);  chk("set_wins", v, 32'h1);

        bus_wr(32'h04, 32'hAAAA);
        bus_wr(32'h08, 32'h5555);
        bus_wr(32'h28, 32'h20);
        @(posedge clk); #1;
        gpio_dat_i[0] = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        rstn = 1'b0; sys_addr = 32'h04; sys_ren = 1'b1;
        @(posedge clk); #1;
        chk("mid_rst_out", 32'(gpio_dat_o), 32'd0);
        chk("mid_rst_dir", 32'(gpio_dir_o), 32'd0);
        chk("mid_rst_irq", 32'(irq_o), 32'd0);
        chk("mid_rst_ack", 32'(sys_ack), 32'd0);
        chk("mid_rst_rdata", sys_rdata, 32'd0);
        sys_ren = 1'b0;
        @(posedge clk); #1;
        rstn = 1'b1;
        bus_rd(32'h28, v);  chk("mid_rst_deb", v, 32'd0);
        bus_rd(32'h3C, v);  chk("rd_3c", v, 32'd0);
        bus_rd(32'h24, v);  chk("mid_rst_sts", v, 32'd0);
        bus_rd(32'h18, v);  chk("mid_rst_in", v, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/red_pitaya_gpio.md
RED_PITAYA_GPIO -- requirements
Module: red_pitaya_gpio

Interface
REQ-001 Parameter NGPIO, default 16: number of GPIO pins, legal range 1..32.
REQ-002 Parameter CW, default 16: debounce counter width, legal range 1..32.
REQ-003 Parameter DEB_RST, default 0: reset value of DEB_LEN.
REQ-004 Port clk_i, input, 1 bit: the single clock for all logic.
REQ-005 Port rstn_i, input, 1 bit: reset, synchronous, active-low.
REQ-006 Port gpio_dat_i, input, NGPIO bits: asynchronous pin inputs.
REQ-007 Port gpio_dat_o, output, NGPIO bits: pin output data.
REQ-008 Port gpio_dir_o, output, NGPIO bits: per-pin output enable, 1 = output.
REQ-009 Port irq_o, output, 1 bit: registered OR of IRQ_STATUS.
REQ-010 Port sys_addr, input, 32 bits: bus address; only [19:0] is decoded.
REQ-011 Port sys_wdata, input, 32 bits: bus write data.
REQ-012 Port sys_wen, input, 1 bit: bus write strobe.
REQ-013 Port sys_ren, input, 1 bit: bus read strobe.
REQ-014 Port sys_rdata, output, 32 bits: bus read data.
REQ-015 Port sys_err, output, 1 bit: bus error, always 0.
REQ-016 Port sys_ack, output, 1 bit: bus acknowledge.

Function
REQ-017 sys_ack SHALL equal (sys_wen|sys_ren) delayed one cycle, at every address; sys_rdata is valid in the same cycle as sys_ack.
REQ-018 Register map (address: name, access):
- 0x00 CFG, RO: {8'h0, 8'(CW), 8'(NGPIO), 8'h02}
- 0x04 DIR, RW
- 0x08 OUT, RW
- 0x0C SET, WO
- 0x10 CLR, WO
- 0x14 TGL, WO
- 0x18 IN, RO
- 0x1C IRQ_EN_RISE, RW
- 0x20 IRQ_EN_FALL, RW
- 0x24 IRQ_STATUS, R/W1C
- 0x28 DEB_LEN, RW, CW bits
- Other addresses read 0 and ignore writes.
REQ-019 All register fields are NGPIO bits wide unless stated; unused upper read bits are 0; WO registers read 0.
REQ-020 A write to SET/CLR/TGL SHALL update OUT one cycle after the write: OUT|=wdata, OUT&=~wdata or OUT^=wdata respectively.
REQ-021 gpio_dat_o = OUT and gpio_dir_o = DIR, driven directly from registers.
REQ-022 Each input SHALL pass through a 2-flop synchronizer, then a per-pin debouncer.
REQ-023 Debouncer: while synced != debounced, count up; when count reaches DEB_LEN, load debounced := synced and clear the count; any cycle with synced == debounced clears the count. DEB_LEN = 0 updates one cycle after mismatch.
REQ-024 A glitch shorter than DEB_LEN+1 cycles SHALL NOT change IN.
REQ-025 Writing DEB_LEN SHALL clear all debounce counters in the same cycle.
REQ-026 A rising (falling) edge of debounced pin k with IRQ_EN_RISE[k] (IRQ_EN_FALL[k]) set SHALL set IRQ_STATUS[k] on the next cycle.
REQ-027 Writing 1 to IRQ_STATUS[k] clears it; if an event and a clear hit bit k in the same cycle, set wins.
REQ-028 Disabling an enable bit SHALL NOT clear an already-set status bit.
REQ-029 irq_o = |IRQ_STATUS, registered, one cycle after the status change.
REQ-030 Worst-case pin-to-IN latency: 2 sync + (DEB_LEN+1) debounce cycles.

Reset
REQ-031 On rstn_i low at a clk_i edge: DIR, OUT, IRQ_EN_*, IRQ_STATUS, synchronizers, debounced values, counters, irq_o, sys_ack and sys_err are 0; DEB_LEN = DEB_RST; sys_rdata = 0.
REQ-032 Reset asserted mid-debounce SHALL discard the count; no edge event is generated on the first cycles after reset because debounced value restarts at 0 and rising edges seen after reset are real events.

Structure
REQ-033 Package red_pitaya_gpio_pkg holds the register address constants and the CFG version constant.
REQ-034 Sub-module red_pitaya_gpio_deb, one instance per pin via generate, contains synchronizer, counter and debounced flop.

Verification
REQ-035 Write DIR=0x00FF, OUT=0x0F0F; read back -> gpio_dir_o=0x00FF, gpio_dat_o=0x0F0F, ack one cycle after each strobe.
REQ-036 OUT=0x00F0; SET 0x0003; CLR 0x0010; TGL 0x8001 -> OUT reads 0x80E2.
REQ-037 DEB_LEN=4; pin0 high for 4 cycles then low -> IN stays 0; high for 10 cycles -> IN[0]=1 at most 2+5 cycles after the edge.
REQ-038 IRQ_EN_RISE=0x1, pin0 rises -> IRQ_STATUS=0x1, irq_o=1; write 0x1 to 0x24 -> status 0, irq_o 0 one cycle later.
REQ-039 W1C of bit 0 issued in the same cycle as a new enabled edge -> IRQ_STATUS[0] stays 1.
REQ-040 Reset asserted mid-debounce with DEB_LEN=0x20 -> all outputs 0, DEB_LEN reads DEB_RST, and a read at 0x3C returns 0 with ack.
